rate_enable_gen: RTL and testbench
==================================

RATE_ENABLE_GEN -- requirements
Module: rate_enable_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of rate channels (ch0 = sideband, ch1..3 = gen2/gen3/gen4 lane rates).
REQ-002 SHALL have parameter ACC_W, default 24, accumulator/increment width in bits.
REQ-003 SHALL have parameter RST_HOLD, default 3, count of ch0 ticks for which sys_rst_n is held low after reset.
REQ-004 SHALL have port local_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ch_en  in  NUM_CH  per-channel run enable.
REQ-007 SHALL have port inc  in  NUM_CH*ACC_W  packed phase increments, channel i at bits [i*ACC_W +: ACC_W].
REQ-008 SHALL have port inc_load  in  1  one-cycle strobe that samples inc into the internal increment registers.
REQ-009 SHALL have port gen_sel  in  $clog2(NUM_CH)  requested lane-rate channel.
REQ-010 SHALL have port tick  out  NUM_CH  one-cycle rate strobe per channel.
REQ-011 SHALL have port lane_tick  out  1  strobe of the active lane-rate channel.
REQ-012 SHALL have port gen_active  out  $clog2(NUM_CH)  currently applied channel selection.
REQ-013 SHALL have port switch_busy  out  1  high while a selection change is pending.
REQ-014 SHALL have port sys_rst_n  out  1  sequenced active-low reset for downstream logic.

Function
REQ-015 Per channel, with ch_en[i]=1, each edge SHALL compute {c,acc} <= acc + inc_reg[i] (ACC_W+1-bit sum) and set tick[i] <= c; latency from overflow to tick is one edge.
REQ-016 With ch_en[i]=0, acc[i] SHALL be cleared to 0 and tick[i] SHALL be 0 on the next edge.
REQ-017 inc_reg[i]=0 SHALL never produce a tick; the maximum rate is one tick per cycle.
REQ-018 On inc_load=1, all inc_reg SHALL load from inc and all accumulators and tick bits SHALL clear on the same edge; the first ticks follow from the new increments.
REQ-019 The switch FSM SHALL have states IDLE and PENDING; in IDLE, lane_tick = tick[gen_active].
REQ-020 In IDLE with gen_sel != gen_active, the FSM SHALL latch target <= gen_sel, enter PENDING and set switch_busy=1 on that edge.
REQ-021 In PENDING, lane_tick SHALL be 0 except on the cycle in which tick[target]=1; on that cycle lane_tick=1, and on the following edge gen_active<=target, switch_busy<=0 and the FSM returns to IDLE.
REQ-022 In PENDING, if gen_sel changes to another channel, target SHALL retarget; if gen_sel equals gen_active, the FSM SHALL return to IDLE on the next edge with gen_active unchanged.
REQ-023 If the target channel is disabled, the FSM SHALL remain in PENDING indefinitely; no timeout.
REQ-024 The reset sequencer SHALL have states HOLD and RUN; in HOLD it SHALL count tick[0] pulses, saturating at RST_HOLD.
REQ-025 When the count reaches RST_HOLD, the sequencer SHALL set sys_rst_n <= 1 on the next edge and remain in RUN until rst asserts; inc_load SHALL NOT affect the sequencer.
REQ-026 RST_HOLD=0 SHALL release sys_rst_n on the first edge after rst deasserts.

Reset
REQ-027 rst=0 SHALL immediately clear acc, inc_reg, tick, lane_tick, gen_active, target, switch_busy, the sequencer count and sys_rst_n to 0, and force IDLE/HOLD, including mid-switch and mid-sequence.
REQ-028 After rst deasserts, no tick SHALL occur until inc_load provides nonzero increments.

Structure
REQ-029 The shared package rate_enable_pkg SHALL hold: the default parameters; the sw_state_e {IDLE,PENDING} and seq_state_e {HOLD,RUN} enums; named increment constants for ACC_W=24 at local_clk = 80 GHz (SB 1 MHz, 9.697, 10, 19.394, 20, 40 GHz).
REQ-030 A single sub-module nco_accumulator (one channel: acc, enable, clear, carry tick) SHALL be instantiated NUM_CH times.

Verification
REQ-031 inc ch0=0x800000, inc_load, ch_en=0001 -> tick[0] first on 2nd edge after enable, then every 2 cycles.
REQ-032 inc ch1=0x1F07E5, ch_en[1]=1 for 80000 cycles -> 9697 +/-1 ticks on tick[1].
REQ-033 RST_HOLD=3, ch0=0x800000, rst released -> sys_rst_n=0 through the 3rd tick[0], then 1 on the next edge.
REQ-034 gen_active=1, ch2=0x400000, gen_sel 1->2 -> switch_busy=1 and lane_tick=0 until tick[2]; lane_tick=1 on that cycle; gen_active=2 and busy=0 on the next edge.
REQ-035 inc_load mid-run with unchanged inc -> all tick=0 on the next cycle and phase restarts from 0.
REQ-036 rst=0 during PENDING -> every output 0 without waiting for a clock edge; FSM in IDLE after release.

Source files
------------

// File: rtl/rate_enable_pkg.sv
// Shared definitions for the rate enable generator: defaults, FSM encodings and
// phase increments for a 24-bit accumulator clocked at 80 GHz (inc = f / 80e9 * 2^24).
package rate_enable_pkg;

   localparam int NUM_CH_DEF   = 4;
   localparam int ACC_W_DEF    = 24;
   localparam int RST_HOLD_DEF = 3;

   typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} sw_state_e;
   typedef enum logic {HOLD = 1'b0, RUN = 1'b1}     seq_state_e;

   localparam logic [23:0] INC_SB_1M      = 24'h0000D2;
   localparam logic [23:0] INC_GEN2_9G697 = 24'h1F07E5;
   localparam logic [23:0] INC_10G        = 24'h200000;
   localparam logic [23:0] INC_GEN3_19G394 = 24'h3E0FCA;
   localparam logic [23:0] INC_20G        = 24'h400000;
   localparam logic [23:0] INC_GEN4_40G   = 24'h800000;

endpackage

// File: rtl/rate_enable_gen_nco.sv
// One-channel phase accumulator: the carry out of acc + inc becomes a one-cycle tick.
// Latency: tick registered one edge after overflow; no backpressure.
module nco_accumulator
   import rate_enable_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             local_clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [ACC_W-1:0] inc,
   output logic             tick
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, inc};

   always_ff @(posedge local_clk or negedge rst) begin
      if (!rst) begin
         acc  <= '0;
         tick <= 1'b0;
      end else if (clr || !en) begin
         acc  <= '0;
         tick <= 1'b0;
      end else begin
         acc  <= sum[ACC_W-1:0];
         tick <= sum[ACC_W];
      end
   end

endmodule

// File: rtl/rate_enable_gen.sv
// NCO rate strobes per channel, glitch-free lane-rate switch and a tick-counted downstream reset.
// Latency: ticks one edge after overflow; switches commit on the edge after the target's tick.
module rate_enable_gen
   import rate_enable_pkg::*;
#(
   parameter int NUM_CH   = NUM_CH_DEF,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int RST_HOLD = RST_HOLD_DEF
) (
   input  logic                       local_clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_en,
   input  logic [NUM_CH*ACC_W-1:0]    inc,
   input  logic                       inc_load,
   input  logic [$clog2(NUM_CH)-1:0]  gen_sel,
   output logic [NUM_CH-1:0]          tick,
   output logic                       lane_tick,
   output logic [$clog2(NUM_CH)-1:0]  gen_active,
   output logic                       switch_busy,
   output logic                       sys_rst_n
);

   localparam int SEL_W = $clog2(NUM_CH);
   localparam int CNT_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(RST_HOLD);

   logic [ACC_W-1:0] inc_reg [NUM_CH];

   always_ff @(posedge local_clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) inc_reg[i] <= '0;
      end else if (inc_load) begin
         for (int i = 0; i < NUM_CH; i++) inc_reg[i] <= inc[i*ACC_W +: ACC_W];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      nco_accumulator #(.ACC_W(ACC_W)) u_nco (
         .local_clk (local_clk),
         .rst       (rst),
         .en        (ch_en[g]),
         .clr       (inc_load),
         .inc       (inc_reg[g]),
         .tick      (tick[g])
      );
   end

   // Lane-rate switch: the new selection only takes effect right after one of its own ticks
   sw_state_e        sw_state, sw_next;
   logic [SEL_W-1:0] target, target_next, gen_active_next;

   always_ff @(posedge local_clk or negedge rst) begin
      if (!rst) begin
         sw_state   <= IDLE;
         target     <= '0;
         gen_active <= '0;
      end else begin
         sw_state   <= sw_next;
         target     <= target_next;
         gen_active <= gen_active_next;
      end
   end

   always_comb begin
      sw_next         = sw_state;
      target_next     = target;
      gen_active_next = gen_active;
      case (sw_state)
         IDLE: begin
            if (gen_sel != gen_active) begin
               sw_next     = PENDING;
               target_next = gen_sel;
            end
         end
         PENDING: begin
            if (tick[target]) begin
               sw_next         = IDLE;
               gen_active_next = target;
            end else if (gen_sel == gen_active) begin
               sw_next = IDLE;
            end else begin
               target_next = gen_sel;
            end
         end
         default: sw_next = IDLE;
      endcase
   end

   always_comb begin
      lane_tick   = (sw_state == IDLE) ? tick[gen_active] : tick[target];
      switch_busy = (sw_state == PENDING);
   end

   // Downstream reset sequencer; deliberately blind to inc_load
   seq_state_e       seq_state, seq_next;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_next;

   always_ff @(posedge local_clk or negedge rst) begin
      if (!rst) begin
         seq_state <= HOLD;
         hold_cnt  <= '0;
      end else begin
         seq_state <= seq_next;
         hold_cnt  <= hold_cnt_next;
      end
   end

   always_comb begin
      seq_next      = seq_state;
      hold_cnt_next = hold_cnt;
      if (seq_state == HOLD) begin
         if (tick[0] && (hold_cnt != HOLD_CNT)) hold_cnt_next = hold_cnt + CNT_W'(1);
         if (hold_cnt_next == HOLD_CNT) seq_next = RUN;
      end
   end

   always_comb begin
      sys_rst_n = (seq_state == RUN);
   end

endmodule

// File: tb/tb_rate_enable_gen.sv
// Bench for rate_enable_gen: directed vector table, hand-built switch/reset sequences,
// and randomized traffic checked against an arithmetic model of the rate generator.
module tb_rate_enable_gen;
   import rate_enable_pkg::*;

   localparam int NCH = 4;
   localparam int AW  = 24;
   localparam int RH  = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [NCH-1:0]      ch_en;
   logic [NCH*AW-1:0]   inc;
   logic                inc_load;
   logic [1:0]          gen_sel;
   logic [NCH-1:0]      tick, z_tick;
   logic                lane_tick, z_lane_tick;
   logic [1:0]          gen_active, z_gen_active;
   logic                switch_busy, z_switch_busy;
   logic                sys_rst_n, z_sys_rst_n;

   always #5 clk = ~clk;

   rate_enable_gen #(.NUM_CH(NCH), .ACC_W(AW), .RST_HOLD(RH)) dut (
      .local_clk(clk), .rst(rst), .ch_en(ch_en), .inc(inc), .inc_load(inc_load),
      .gen_sel(gen_sel), .tick(tick), .lane_tick(lane_tick), .gen_active(gen_active),
      .switch_busy(switch_busy), .sys_rst_n(sys_rst_n)
   );

   rate_enable_gen #(.NUM_CH(NCH), .ACC_W(AW), .RST_HOLD(0)) dut_z (
      .local_clk(clk), .rst(rst), .ch_en(ch_en), .inc(inc), .inc_load(inc_load),
      .gen_sel(gen_sel), .tick(z_tick), .lane_tick(z_lane_tick), .gen_active(z_gen_active),
      .switch_busy(z_switch_busy), .sys_rst_n(z_sys_rst_n)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: tick count after k enabled edges is floor(k*inc / 2^AW)
   longint         m_inc [NCH];
   longint         m_k   [NCH];
   logic [NCH-1:0] m_tick;
   bit             m_pend;
   int             m_act, m_tgt, m_edges, m_t0cnt;

   task automatic chk(input string nm, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_inc[i] = 0;
         m_k[i]   = 0;
      end
      m_tick  = '0;
      m_pend  = 0;
      m_act   = 0;
      m_tgt   = 0;
      m_edges = 0;
      m_t0cnt = 0;
   endtask

   task automatic model_edge();
      logic [NCH-1:0] old;
      old = m_tick;
      if (!rst) begin
         model_reset();
         return;
      end
      m_edges++;
      if (old[0]) m_t0cnt++;
      if (!m_pend) begin
         if (gen_sel != m_act) begin
            m_pend = 1;
            m_tgt  = gen_sel;
         end
      end else if (old[m_tgt]) begin
         m_act  = m_tgt;
         m_pend = 0;
      end else if (gen_sel == m_act) begin
         m_pend = 0;
      end else begin
         m_tgt = gen_sel;
      end
      for (int i = 0; i < NCH; i++) begin
         if (inc_load) begin
            m_inc[i]  = inc[i*AW +: AW];
            m_k[i]    = 0;
            m_tick[i] = 1'b0;
         end else if (!ch_en[i]) begin
            m_k[i]    = 0;
            m_tick[i] = 1'b0;
         end else begin
            m_k[i]++;
            m_tick[i] = ((m_k[i] * m_inc[i]) >> AW) != (((m_k[i] - 1) * m_inc[i]) >> AW);
         end
      end
   endtask

   task automatic check_all();
      chk("tick", tick, m_tick);
      chk("lane_tick", lane_tick, m_pend ? m_tick[m_tgt] : m_tick[m_act]);
      chk("gen_active", gen_active, m_act);
      chk("switch_busy", switch_busy, m_pend);
      chk("sys_rst_n", sys_rst_n, (m_edges >= 1 && m_t0cnt >= RH));
      chk("sys_rst_n_hold0", z_sys_rst_n, (m_edges >= 1));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      check_all();
   endtask

   typedef struct {
      logic [NCH-1:0] en;
      logic           ld;
      logic [AW-1:0]  inc0;
      logic [NCH-1:0] exp_tick;
      logic           exp_lane;
      logic           exp_srn;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      bit  seen;
      tbl[0] = '{4'b0001, 1'b1, 24'h800000, 4'b0000, 1'b0, 1'b0};
      tbl[1] = '{4'b0001, 1'b0, 24'h800000, 4'b0000, 1'b0, 1'b0};
      tbl[2] = '{4'b0001, 1'b0, 24'h800000, 4'b0001, 1'b1, 1'b0};
      tbl[3] = '{4'b0001, 1'b0, 24'h800000, 4'b0000, 1'b0, 1'b0};
      tbl[4] = '{4'b0001, 1'b0, 24'h800000, 4'b0001, 1'b1, 1'b0};
      tbl[5] = '{4'b0001, 1'b0, 24'h800000, 4'b0000, 1'b0, 1'b0};
      tbl[6] = '{4'b0001, 1'b0, 24'h800000, 4'b0001, 1'b1, 1'b0};
      tbl[7] = '{4'b0001, 1'b0, 24'h800000, 4'b0000, 1'b0, 1'b1};
      tbl[8] = '{4'b0001, 1'b0, 24'h800000, 4'b0001, 1'b1, 1'b1};

      rst = 1'b0; ch_en = '0; inc = '0; inc_load = 1'b0; gen_sel = '0;
      model_reset();
      #1;
      chk("rst_tick", tick, 0);
      chk("rst_lane", lane_tick, 0);
      chk("rst_active", gen_active, 0);
      chk("rst_busy", switch_busy, 0);
      chk("rst_srn", sys_rst_n, 0);
      step();
      step();

      // Release; increments present on the bus but never loaded must not tick
      rst = 1'b1;
      chk("hold0_before_edge", z_sys_rst_n, 0);
      ch_en = '1;
      inc   = {NCH{24'h123456}};
      step();
      chk("hold0_first_edge", z_sys_rst_n, 1);
      step();
      step();
      chk("no_tick_unloaded", tick, 0);

      // 40 GHz on ch0: first tick on the 2nd edge, then every 2 cycles; sys_rst_n after 3rd tick
      for (int v = 0; v < 9; v++) begin
         ch_en    = tbl[v].en;
         inc_load = tbl[v].ld;
         inc      = '0;
         inc[AW-1:0] = tbl[v].inc0;
         step();
         chk($sformatf("vec%0d_tick", v), tick, tbl[v].exp_tick);
         chk($sformatf("vec%0d_lane", v), lane_tick, tbl[v].exp_lane);
         chk($sformatf("vec%0d_srn", v), sys_rst_n, tbl[v].exp_srn);
      end

      // Reload with identical increments restarts the phase
      inc_load = 1'b1;
      step();
      chk("reload_clear", tick, 0);
      inc_load = 1'b0;
      step();
      chk("reload_phase1", tick, 0);
      step();
      chk("reload_phase2", tick, 1);
      chk("reload_srn_kept", sys_rst_n, 1);

      // Switch to ch1 then ch2
      inc = '0;
      inc[0*AW +: AW] = INC_GEN4_40G;
      inc[1*AW +: AW] = INC_10G;
      inc[2*AW +: AW] = INC_20G;
      ch_en = 4'b0111; inc_load = 1'b1; gen_sel = 2'd1;
      step();
      inc_load = 1'b0;
      for (int n = 0; n < 40 && gen_active != 2'd1; n++) step();
      chk("switch_to_1", gen_active, 1);
      gen_sel = 2'd2;
      step();
      chk("switch_busy_rise", switch_busy, 1);
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         if (tick[2]) begin
            chk("switch_lane_on_target", lane_tick, 1);
            step();
            chk("switch_commit_active", gen_active, 2);
            chk("switch_commit_busy", switch_busy, 0);
            seen = 1;
            break;
         end
         chk("switch_lane_quiet", lane_tick, 0);
         chk("switch_busy_held", switch_busy, 1);
         step();
      end
      chk("switch_completed", seen, 1);

      // Disabled target waits forever; selecting the active channel cancels
      gen_sel = 2'd3;
      step();
      repeat (20) step();
      chk("disabled_target_busy", switch_busy, 1);
      chk("disabled_target_active", gen_active, 2);
      gen_sel = 2'd2;
      step();
      chk("cancel_busy", switch_busy, 0);
      chk("cancel_active", gen_active, 2);

      // Retarget from disabled ch3 to ch1
      gen_sel = 2'd3;
      step();
      gen_sel = 2'd1;
      for (int n = 0; n < 40 && gen_active != 2'd1; n++) step();
      chk("retarget_active", gen_active, 1);

      // Asynchronous reset in the middle of a pending switch
      gen_sel = 2'd3;
      step();
      chk("pre_arst_busy", switch_busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_tick", tick, 0);
      chk("arst_lane", lane_tick, 0);
      chk("arst_active", gen_active, 0);
      chk("arst_busy", switch_busy, 0);
      chk("arst_srn", sys_rst_n, 0);
      model_reset();
      gen_sel = 2'd0;
      step();
      rst = 1'b1;
      step();
      chk("post_arst_idle", switch_busy, 0);

      // Long-run rate check on the gen2 increment
      inc = '0;
      inc[1*AW +: AW] = INC_GEN2_9G697;
      ch_en = 4'b0010; inc_load = 1'b1;
      step();
      inc_load = 1'b0;
      cnt = 0;
      repeat (80000) begin
         step();
         cnt += int'(tick[1]);
      end
      total++;
      if (cnt < 9696 || cnt > 9698) begin
         bad++;
         $display("FAIL rate_gen2: got %0d ticks expected 9697 +/-1", cnt);
      end

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         ch_en    = NCH'($urandom);
         inc_load = ($urandom_range(0, 15) == 0);
         if (inc_load) begin
            for (int i = 0; i < NCH; i++) begin
               case ($urandom_range(0, 4))
                  0: inc[i*AW +: AW] = '0;
                  1: inc[i*AW +: AW] = 24'hFFFFFF;
                  2: inc[i*AW +: AW] = 24'h800000;
                  3: inc[i*AW +: AW] = AW'($urandom_range(1, 255));
                  default: inc[i*AW +: AW] = AW'($urandom);
               endcase
            end
         end
         if ($urandom_range(0, 7) == 0) gen_sel = 2'($urandom_range(0, 3));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
